// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage and 2**ADDR_WIDTH-entry architectural register file.
//
// Selects the write-back value from the MEM/WB outputs, commits it to the
// register file, provides two combinational ID-stage read ports and keeps a
// count of committed (retired) register writes.
//
// Build option:
//   WB_BYPASS_EN - when defined, a read of the register being written in the
//                  current cycle returns the value being written back
//                  (write-through). When undefined, reads always return the
//                  stored value, and the hazard unit must stall one cycle.
//
// Entry 0 is not stored. It always reads as zero, including through the bypass.

module wb_regfile #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   reg_write_in,
    input  logic                   mem_to_reg_in,
    input  logic [DATA_WIDTH-1:0]  read_data_in,
    input  logic [DATA_WIDTH-1:0]  address_in,
    input  logic [ADDR_WIDTH-1:0]  write_back_destination_in,
    input  logic [ADDR_WIDTH-1:0]  read_reg1,
    input  logic [ADDR_WIDTH-1:0]  read_reg2,
    output logic [DATA_WIDTH-1:0]  read_data1,
    output logic [DATA_WIDTH-1:0]  read_data2,
    output logic [DATA_WIDTH-1:0]  wb_data_out,
    output logic [COUNT_WIDTH-1:0] retire_count
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

    // Storage for entries 1..NUM_REGS-1 only; entry 0 has no flops.
    logic [DATA_WIDTH-1:0]  mem_q [1:NUM_REGS-1];
    // Read view of the whole file with entry 0 tied to zero.
    logic [DATA_WIDTH-1:0]  rd_view [NUM_REGS];

    logic                   wr_eff;
    logic [NUM_REGS-1:0]    wr_sel;
    logic [COUNT_WIDTH-1:0] cnt_q;
    logic [COUNT_WIDTH-1:0] cnt_d;

    // Write-back value mux; also exported for forwarding.
    always_comb begin
        wb_data_out = mem_to_reg_in ? read_data_in : address_in;
    end

    // A write to register 0 is dropped entirely: nothing stored, nothing counted.
    always_comb begin
        wr_eff = reg_write_in && (write_back_destination_in != '0);
        wr_sel = '0;
        if (wr_eff) begin
            wr_sel[write_back_destination_in] = 1'b1;
        end
    end

    // Register file storage; reset clears every entry and beats any write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    mem_q[i] <= wb_data_out;
                end
            end
        end
    end

    // Build the read view with the hardwired-zero entry in slot 0.
    always_comb begin
        rd_view[0] = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            rd_view[i] = mem_q[i];
        end
    end

`ifdef WB_BYPASS_EN
    logic bypass1;
    logic bypass2;

    // Write-through: wr_eff already excludes register 0, and reset blocks it.
    always_comb begin
        bypass1    = rst_n && wr_eff && (read_reg1 == write_back_destination_in);
        bypass2    = rst_n && wr_eff && (read_reg2 == write_back_destination_in);
        read_data1 = bypass1 ? wb_data_out : rd_view[read_reg1];
        read_data2 = bypass2 ? wb_data_out : rd_view[read_reg2];
    end
`else
    // Plain array reads; the register being written shows its old value.
    always_comb begin
        read_data1 = rd_view[read_reg1];
        read_data2 = rd_view[read_reg2];
    end
`endif

    // Retired-write counter wraps silently on overflow.
    always_comb begin
        cnt_d = cnt_q;
        if (wr_eff) begin
            cnt_d = cnt_q + COUNT_WIDTH'(1);
        end
    end

    // Counter state; reset has priority over a same-edge write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign retire_count = cnt_q;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Write-back end of the MIPS pipeline. It consumes the MEM/WB pipeline register outputs, selects the write-back value, and commits it to the 32-entry architectural register file. It provides the two combinational read ports used by the ID stage and keeps a retired-write counter for debug and performance checks.

Parameters:
DATA_WIDTH, 32, width of register and write-back data
ADDR_WIDTH, 5, register index width; the file holds 2**ADDR_WIDTH entries
COUNT_WIDTH, 32, width of the retired-write counter

Ports:
clk  input  1  pipeline clock; all state updates on posedge
rst_n  input  1  synchronous active-low reset, sampled on posedge clk
reg_write_in  input  1  write enable from MEM/WB
mem_to_reg_in  input  1  1 = write read_data_in, 0 = write address_in
read_data_in  input  DATA_WIDTH  data-memory load result from MEM/WB
address_in  input  DATA_WIDTH  ALU result from MEM/WB
write_back_destination_in  input  ADDR_WIDTH  destination register index
read_reg1  input  ADDR_WIDTH  ID read port 1 index
read_reg2  input  ADDR_WIDTH  ID read port 2 index
read_data1  output  DATA_WIDTH  port 1 data (combinational)
read_data2  output  DATA_WIDTH  port 2 data (combinational)
wb_data_out  output  DATA_WIDTH  selected write-back value (combinational, for forwarding)
retire_count  output  COUNT_WIDTH  count of committed register writes

Behaviour:
- wb_data_out = mem_to_reg_in ? read_data_in : address_in. Pure mux, zero latency.
- Effective write (wr_eff) = reg_write_in AND write_back_destination_in != 0.
- Posedge clk with rst_n=0:
  - all entries cleared to 0;
  - retire_count cleared to 0;
  - any write on the same edge is discarded. Reset has priority.
- Posedge clk with rst_n=1 and wr_eff=1:
  - entry[write_back_destination_in] <= wb_data_out;
  - retire_count <= retire_count + 1.
- reg_write_in=1 with destination 0: nothing stored, counter unchanged.
- Entry 0 is hardwired to 0. Reads of index 0 always return 0, including through the bypass path.
- Read ports are combinational from the array (plus bypass, see Optional Feature). Read latency is 0; write latency is 1 edge.
- Both read ports may address the same register, or the write target, simultaneously. Each port resolves independently.
- retire_count wraps from 2**COUNT_WIDTH-1 to 0 with no flag and no saturation.
- Reset asserted mid-stream: the file reads all-zero from the edge after reset is sampled, until the first post-reset write.
- No X propagation: unwritten entries read 0 after the first reset.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined: write-through bypass. If wr_eff=1 and read_regN == write_back_destination_in, read_dataN = wb_data_out in the same cycle. ID therefore sees the value being written back, so no same-cycle WB to ID hazard exists. The bypass is gated by rst_n=1.
- Not defined: read_dataN always returns the stored array value. A read of the register being written returns the old value until after the edge, and the hazard unit must stall one cycle.

Test Plan:
1. rst_n=0 for 2 edges, then rst_n=1 -> read_data1/2 = 0 for indices 0, 5, 31; retire_count=0.
2. reg_write_in=1, mem_to_reg_in=0, address_in=0x0000_00AA, dest=8; next cycle read_reg1=8 -> read_data1=0x0000_00AA, retire_count=1.
3. reg_write_in=1, mem_to_reg_in=1, read_data_in=0xDEAD_BEEF, dest=0 -> read of index 0 = 0 in the same cycle and after the edge; retire_count unchanged.
4. dest=9, address_in=0x1234_5678, read_reg2=9 in the same cycle -> read_data2=0x1234_5678 with WB_BYPASS_EN defined; old value (0) without it. Both builds read 0x1234_5678 after the edge.
5. Write 0x55 to register 3, then on the next edge assert rst_n=0 together with reg_write_in=1, dest=4, address_in=0x77 -> afterwards registers 3 and 4 read 0 and retire_count=0.
6. Force retire_count to 0xFFFF_FFFF via hierarchical deposit, perform one effective write -> retire_count=0x0000_0000.
